// File: rtl/ram_rcmd_sched.sv
// ram_rcmd_sched: read command queue with credit gating and RAM-latency tag tracking
module ram_rcmd_sched #(
   parameter int C_ID     = 16,
   parameter int C_RAM_AW = 15,
   parameter int C_CMD_AW = 3,
   parameter int C_RL     = 2,
   parameter int C_CRED   = 4
) (
   input  logic                       aclk_s,
   input  logic                       rst_n,
   input  logic [C_ID+C_RAM_AW+1:0]   cmd_info,
   input  logic                       cmd_push,
   output logic                       cmd_full,
   output logic [C_CMD_AW:0]          cmd_level,
   output logic                       ram_rd_req,
   output logic [C_RAM_AW:0]          ram_addr,
   input  logic                       ram_rd_ack,
   input  logic                       ram_vld,
   input  logic                       rdf_pop,
   output logic                       rd_vld,
   output logic [C_ID-1:0]            axi_id,
   output logic                       axi_last,
   output logic                       lat_err
);
   localparam int W     = C_ID + C_RAM_AW + 2;
   localparam int DEPTH = 2 ** C_CMD_AW;
   localparam int CW    = $clog2(C_CRED + 1);
   localparam logic [C_CMD_AW:0] L_ONE = (C_CMD_AW+1)'(1);
   localparam logic [CW-1:0]     C_ONE = CW'(1);
   localparam logic [CW-1:0]     C_MAX = CW'(C_CRED);

   logic [W-1:0]        mem_q [DEPTH];
   logic [C_CMD_AW-1:0] wp_q, rp_q;
   logic [C_CMD_AW:0]   level_q, level_d;
   logic [CW-1:0]       cred_q, cred_d;
   logic [C_RL:1]       vld_q, last_q;
   logic [C_ID-1:0]     id_q [1:C_RL];
   logic                lat_err_q;
   logic [W-1:0]        head;
   logic                push, pop, sat, inc, miss;

   // Entry layout is {last, id, addr}; the head entry drives the RAM request
   assign head       = mem_q[rp_q];
   assign ram_addr   = head[C_RAM_AW:0];
   assign cmd_full   = level_q[C_CMD_AW];
   assign cmd_level  = level_q;
   assign push       = cmd_push & ~cmd_full;
   assign ram_rd_req = (|level_q) & (|cred_q);
   assign pop        = ram_rd_ack & ram_rd_req;
   // A credit return with all credits home is a protocol error and is dropped
   assign sat        = rdf_pop & (cred_q == C_MAX);
   assign inc        = rdf_pop & ~sat;
   // Returning data and the oldest tag must arrive together
   assign miss       = ram_vld ^ vld_q[C_RL];
   assign rd_vld     = ram_vld & vld_q[C_RL];
   assign axi_id     = id_q[C_RL];
   assign axi_last   = last_q[C_RL];
   assign lat_err    = lat_err_q;

   // Next occupancy and credit count; simultaneous inc/dec cancel out
   always_comb begin
      level_d = (push & ~pop) ? level_q + L_ONE : (pop & ~push) ? level_q - L_ONE : level_q;
      cred_d  = (pop & ~inc) ? cred_q - C_ONE : (inc & ~pop) ? cred_q + C_ONE : cred_q;
   end

   // Queue storage needs no reset; occupancy decides what is visible
   always_ff @(posedge aclk_s) begin
      if (push) mem_q[wp_q] <= cmd_info;
   end

   // Queue pointers, credits, tag pipeline and sticky error
   always_ff @(posedge aclk_s) begin
      if (!rst_n) begin
         wp_q      <= '0;
         rp_q      <= '0;
         level_q   <= '0;
         cred_q    <= C_MAX;
         vld_q     <= '0;
         last_q    <= '0;
         for (int i = 1; i <= C_RL; i++) id_q[i] <= '0;
         lat_err_q <= 1'b0;
      end else begin
         wp_q      <= push ? wp_q + 1'b1 : wp_q;
         rp_q      <= pop ? rp_q + 1'b1 : rp_q;
         level_q   <= level_d;
         cred_q    <= cred_d;
         vld_q[1]  <= pop;
         id_q[1]   <= pop ? head[C_RAM_AW+1 +: C_ID] : '0;
         last_q[1] <= pop & head[W-1];
         for (int i = 2; i <= C_RL; i++) begin
            vld_q[i]  <= vld_q[i-1];
            id_q[i]   <= id_q[i-1];
            last_q[i] <= last_q[i-1];
         end
         lat_err_q <= lat_err_q | miss | sat;
      end
   end
endmodule
